// File: rtl/lsu_stb_pkg.sv
// lsu_stb_pkg: shared store-buffer sizing and pointer type
package lsu_stb_pkg;
  localparam int STB_DEPTH = 8;
  localparam int STB_PTRW = 3;
  typedef logic [STB_PTRW:0] stb_ptr_t;
endpackage

// File: rtl/lsu_stb_ptr.sv
// lsu_stb_ptr: wrap-bit pointer register with increment/decrement enables
module lsu_stb_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else ptr <= ptr + W'(inc) - W'(dec);
  end
endmodule

// File: rtl/lsu_stb_ptr_ctl.sv
// lsu_stb_ptr_ctl: store buffer allocation, commit/rollback, in-order issue and dealloc
module lsu_stb_ptr_ctl
  import lsu_stb_pkg::*;
#(
  parameter int DEPTH = STB_DEPTH,
  parameter int PTRW = STB_PTRW
) (
  input  logic            rclk,
  input  logic            reset,
  input  logic            st_wr_m,
  input  logic            st_flush_w,
  input  logic            pcx_grant,
  input  logic            cpx_st_ack,
  output logic [DEPTH-1:0] stb_clk_en_l,
  output logic [PTRW-1:0] stb_wrptr,
  output logic [DEPTH-1:0] stb_valid,
  output logic            stb_full,
  output logic            stb_empty,
  output logic [PTRW:0]   stb_cnt,
  output logic            stb_pcx_rq_vld,
  output logic [PTRW-1:0] stb_pcx_rq_ptr,
  output logic            stb_ovfl_err,
  output logic            stb_unfl_err
);
  logic [PTRW:0] wptr, iptr, dptr;
  logic [DEPTH-1:0] commit;
  logic [PTRW-1:0] wr_idx, idx;
  logic wr_w, flush, replace, wr_acc, grant, ack;
  assign flush = wr_w && st_flush_w;
  assign replace = flush && st_wr_m;
  assign stb_full = (wptr[PTRW-1:0] == dptr[PTRW-1:0]) && (wptr[PTRW] != dptr[PTRW]);
  assign wr_acc = st_wr_m && (!stb_full || replace);
  assign idx = replace ? wptr[PTRW-1:0] - PTRW'(1) : wptr[PTRW-1:0];
  assign stb_wrptr = idx;
  assign stb_clk_en_l = (reset || !wr_acc) ? '1 : ~(DEPTH'(1) << idx);
  assign stb_cnt = wptr - dptr;
  assign stb_empty = stb_cnt == '0;
  assign stb_pcx_rq_ptr = iptr[PTRW-1:0];
  assign stb_pcx_rq_vld = (iptr != wptr) && commit[iptr[PTRW-1:0]];
  assign grant = pcx_grant && stb_pcx_rq_vld;
  assign ack = cpx_st_ack && (dptr != iptr);
  lsu_stb_ptr #(.W(PTRW+1)) u_wptr (.clk(rclk), .rst(reset), .inc(wr_acc && !replace), .dec(flush && !st_wr_m), .ptr(wptr));
  lsu_stb_ptr #(.W(PTRW+1)) u_iptr (.clk(rclk), .rst(reset), .inc(grant), .dec(1'b0), .ptr(iptr));
  lsu_stb_ptr #(.W(PTRW+1)) u_dptr (.clk(rclk), .rst(reset), .inc(ack), .dec(1'b0), .ptr(dptr));
  always_ff @(posedge rclk) begin
    if (reset) begin
      stb_valid <= '0;
      commit <= '0;
      wr_w <= 1'b0;
      wr_idx <= '0;
      stb_ovfl_err <= 1'b0;
      stb_unfl_err <= 1'b0;
    end else begin
      if (ack) begin
        stb_valid[dptr[PTRW-1:0]] <= 1'b0;
        commit[dptr[PTRW-1:0]] <= 1'b0;
      end
      if (wr_w) begin
        if (st_flush_w) stb_valid[wr_idx] <= 1'b0;
        else commit[wr_idx] <= 1'b1;
      end
      if (wr_acc) begin
        stb_valid[idx] <= 1'b1;
        commit[idx] <= 1'b0;
      end
      wr_w <= wr_acc;
      wr_idx <= idx;
      stb_ovfl_err <= stb_ovfl_err || (st_wr_m && !wr_acc);
      stb_unfl_err <= stb_unfl_err || (cpx_st_ack && !ack);
    end
  end
endmodule

// File: tb/tb_lsu_stb_ptr_ctl.sv
// tb_lsu_stb_ptr_ctl: directed vector table plus hand-written reset-under-load sequence
module tb_lsu_stb_ptr_ctl;
  logic rclk = 1'b0;
  logic reset, st_wr_m, st_flush_w, pcx_grant, cpx_st_ack;
  logic [7:0] stb_clk_en_l, stb_valid;
  logic [2:0] stb_wrptr, stb_pcx_rq_ptr;
  logic [3:0] stb_cnt;
  logic stb_full, stb_empty, stb_pcx_rq_vld, stb_ovfl_err, stb_unfl_err;
  int applied = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0] in;
    logic [7:0] en_l;
    logic [7:0] vld;
    logic [3:0] cnt;
    logic rq;
    logic [2:0] rp;
    logic ovf;
    logic unf;
  } vec_t;
  vec_t tv[$];

  lsu_stb_ptr_ctl dut (
    .rclk(rclk), .reset(reset), .st_wr_m(st_wr_m), .st_flush_w(st_flush_w),
    .pcx_grant(pcx_grant), .cpx_st_ack(cpx_st_ack), .stb_clk_en_l(stb_clk_en_l),
    .stb_wrptr(stb_wrptr), .stb_valid(stb_valid), .stb_full(stb_full),
    .stb_empty(stb_empty), .stb_cnt(stb_cnt), .stb_pcx_rq_vld(stb_pcx_rq_vld),
    .stb_pcx_rq_ptr(stb_pcx_rq_ptr), .stb_ovfl_err(stb_ovfl_err), .stb_unfl_err(stb_unfl_err)
  );

  always #5 rclk = ~rclk;

  task automatic add(input logic [4:0] in, input logic [7:0] en_l, input logic [7:0] vld,
                     input int cnt, input logic rq, input int rp, input logic ovf, input logic unf);
    vec_t v;
    v.in = in;
    v.en_l = en_l;
    v.vld = vld;
    v.cnt = 4'(cnt);
    v.rq = rq;
    v.rp = 3'(rp);
    v.ovf = ovf;
    v.unf = unf;
    tv.push_back(v);
  endtask

  task automatic cmp(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    @(negedge rclk);
    {reset, st_wr_m, st_flush_w, pcx_grant, cpx_st_ack} = in;
    #1;
  endtask

  initial begin
    {reset, st_wr_m, st_flush_w, pcx_grant, cpx_st_ack} = 5'b10000;
    repeat (2) @(posedge rclk);
    // in = {reset, st_wr_m, st_flush_w, pcx_grant, cpx_st_ack}; expectations are pre-edge values
    add(5'b11000, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(5'b01000, ~(8'h01 << i), (8'h01 << i) - 8'h01, i, i >= 2, 0, 0, 0);
    add(5'b01000, 8'hFF, 8'hFF, 8, 1, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'hFF, 8, 1, 0, 1, 0);
    add(5'b10000, 8'hFF, 8'hFF, 8, 1, 0, 1, 0);
    add(5'b01000, 8'hFE, 8'h00, 0, 0, 0, 0, 0);
    add(5'b00100, 8'hFF, 8'h01, 1, 0, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
    add(5'b01000, 8'hFE, 8'h00, 0, 0, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'h01, 1, 0, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'h01, 1, 1, 0, 0, 0);
    add(5'b10000, 8'hFF, 8'h01, 1, 1, 0, 0, 0);
    add(5'b01000, 8'hFE, 8'h00, 0, 0, 0, 0, 0);
    add(5'b01100, 8'hFE, 8'h01, 1, 0, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'h01, 1, 0, 0, 0, 0);
    add(5'b00010, 8'hFF, 8'h01, 1, 1, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'h01, 1, 0, 1, 0, 0);
    add(5'b00001, 8'hFF, 8'h01, 1, 0, 1, 0, 0);
    add(5'b00000, 8'hFF, 8'h00, 0, 0, 1, 0, 0);
    add(5'b10000, 8'hFF, 8'h00, 0, 0, 1, 0, 0);
    add(5'b01000, 8'hFE, 8'h00, 0, 0, 0, 0, 0);
    add(5'b01000, 8'hFD, 8'h01, 1, 0, 0, 0, 0);
    add(5'b01000, 8'hFB, 8'h03, 2, 1, 0, 0, 0);
    for (int j = 0; j < 3; j++)
      add(5'b00010, 8'hFF, 8'h07, 3, 1, j, 0, 0);
    add(5'b00001, 8'hFF, 8'h07, 3, 0, 3, 0, 0);
    add(5'b00001, 8'hFF, 8'h06, 2, 0, 3, 0, 0);
    add(5'b00001, 8'hFF, 8'h04, 1, 0, 3, 0, 0);
    add(5'b00001, 8'hFF, 8'h00, 0, 0, 3, 0, 0);
    add(5'b00000, 8'hFF, 8'h00, 0, 0, 3, 0, 1);
    add(5'b10000, 8'hFF, 8'h00, 0, 0, 3, 0, 1);
    for (int i = 0; i < 8; i++)
      add(5'b01000, ~(8'h01 << i), (8'h01 << i) - 8'h01, i, i >= 2, 0, 0, 0);
    for (int j = 0; j < 8; j++)
      add(5'b00010, 8'hFF, 8'hFF, 8, 1, j, 0, 0);
    for (int j = 0; j < 8; j++)
      add(5'b00001, 8'hFF, 8'hFF << j, 8 - j, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(5'b01000, ~(8'h01 << k), (8'h01 << k) - 8'h01, k, k >= 2, 0, 0, 0);
    add(5'b00000, 8'hFF, 8'h0F, 4, 1, 0, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].in);
      applied++;
      cmp("clk_en_l", i, stb_clk_en_l, tv[i].en_l);
      cmp("valid", i, stb_valid, tv[i].vld);
      cmp("cnt", i, 8'(stb_cnt), 8'(tv[i].cnt));
      cmp("full", i, 8'(stb_full), 8'(tv[i].cnt == 4'd8));
      cmp("empty", i, 8'(stb_empty), 8'(tv[i].cnt == 4'd0));
      cmp("rq_vld", i, 8'(stb_pcx_rq_vld), 8'(tv[i].rq));
      if (tv[i].rq) cmp("rq_ptr", i, 8'(stb_pcx_rq_ptr), 8'(tv[i].rp));
      cmp("ovfl", i, 8'(stb_ovfl_err), 8'(tv[i].ovf));
      cmp("unfl", i, 8'(stb_unfl_err), 8'(tv[i].unf));
      for (int b = 0; b < 8; b++)
        if (tv[i].en_l[b] == 1'b0) cmp("wrptr", i, 8'(stb_wrptr), 8'(b));
    end

    drive(5'b10000);
    for (int i = 0; i < 8; i++) begin
      drive(5'b01000);
      applied++;
      cmp("fill_en", 100 + i, stb_clk_en_l, ~(8'h01 << i));
    end
    drive(5'b01000);
    applied++;
    cmp("full_drop_en", 200, stb_clk_en_l, 8'hFF);
    cmp("full_flag", 200, 8'(stb_full), 8'd1);
    drive(5'b00000);
    applied++;
    cmp("ovfl_set", 201, 8'(stb_ovfl_err), 8'd1);
    drive(5'b00010);
    applied++;
    cmp("full_rq_ptr", 202, 8'(stb_pcx_rq_ptr), 8'd0);
    drive(5'b00011);
    applied++;
    cmp("ga_rq_ptr", 203, 8'(stb_pcx_rq_ptr), 8'd1);
    cmp("ga_cnt", 203, 8'(stb_cnt), 8'd8);
    drive(5'b00000);
    applied++;
    cmp("after_ga_cnt", 204, 8'(stb_cnt), 8'd7);
    cmp("after_ga_valid", 204, stb_valid, 8'hFE);
    drive(5'b11011);
    applied++;
    cmp("rst_en", 205, stb_clk_en_l, 8'hFF);
    drive(5'b00000);
    applied++;
    cmp("post_rst_valid", 206, stb_valid, 8'h00);
    cmp("post_rst_en", 206, stb_clk_en_l, 8'hFF);
    cmp("post_rst_cnt", 206, 8'(stb_cnt), 8'd0);
    cmp("post_rst_empty", 206, 8'(stb_empty), 8'd1);
    cmp("post_rst_rq", 206, 8'(stb_pcx_rq_vld), 8'd0);
    cmp("post_rst_ovfl", 206, 8'(stb_ovfl_err), 8'd0);
    cmp("post_rst_unfl", 206, 8'(stb_unfl_err), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/lsu_stb_ptr_ctl.md
Name: lsu_stb_ptr_ctl

Overview:
Allocation and pointer control for one thread's 8-entry store buffer (STB).
- Sits directly upstream of the per-entry STB control-state flops. Its one-hot active-low `stb_clk_en_l` selects which entry captures the M-stage store attributes.
- Tracks per-entry valid and commit state; rolls back a W-stage-flushed store.
- Sequences in-order PCX issue and in-order deallocation on CPX store ack.

Parameters:
- DEPTH, 8, number of STB entries; power of 2, 2..8.
- PTRW, 3, log2(DEPTH); all pointers carry one extra wrap bit (PTRW+1 bits).

Ports:
- rclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- st_wr_m  in  1  store in M stage requests an STB entry.
- st_flush_w  in  1  W-stage flush of the store written in the previous cycle.
- pcx_grant  in  1  PCX accepted the current request.
- cpx_st_ack  in  1  CPX store ack for the oldest issued entry.
- stb_clk_en_l  out  DEPTH  active-low one-hot write enable to the entry state flops (combinational).
- stb_wrptr  out  PTRW  entry index being written this cycle.
- stb_valid  out  DEPTH  per-entry allocated.
- stb_full  out  1  count == DEPTH.
- stb_empty  out  1  count == 0.
- stb_cnt  out  PTRW+1  occupied entries.
- stb_pcx_rq_vld  out  1  issuable entry present.
- stb_pcx_rq_ptr  out  PTRW  entry to issue.
- stb_ovfl_err  out  1  sticky: write attempted while full.
- stb_unfl_err  out  1  sticky: ack with no issued-unacked entry.

Behaviour:

Reset (synchronous):
- wptr, iptr, dptr = 0; valid and commit = 0; wr_w = 0; both error flags = 0.
- `stb_clk_en_l` forced all ones while reset is high.
- After reset: `stb_empty` = 1, `stb_full` = 0, `stb_cnt` = 0, `stb_pcx_rq_vld` = 0.

Pointers and count:
- wptr (write), iptr (issue) and dptr (dealloc) are (PTRW+1)-bit with wrap; entry index = low PTRW bits.
- Ordering invariant: dptr <= iptr <= wptr, modulo-wrap.
- count = wptr - dptr, modulo 2^(PTRW+1).
- full when the index bits are equal and the wrap bits differ.

Write, M stage:
- Accepted if st_wr_m && (!full || flush-replace).
- Effective write index idx = wptr, or wptr-1 when replacing (see simultaneous events).
- `stb_clk_en_l[idx]` = 0 in the same cycle; all other bits = 1; `stb_wrptr` = idx.
- Next cycle: valid[idx] = 1, commit[idx] = 0, wptr += 1 unless replacing.
- wr_w register = accepted write; it remembers idx for the W stage.

W stage:
- If wr_w && !st_flush_w: commit[wr_idx] = 1.
- If wr_w && st_flush_w: valid[wr_idx] = 0 and wptr -= 1.
- st_flush_w with wr_w = 0 is ignored.

Simultaneous W flush and new M write (flush-replace):
- The new store reuses the flushed slot (idx = wptr-1).
- wptr is unchanged; valid stays 1; commit = 0.
- The write is allowed even when full.

Write while full without flush-replace:
- Dropped; no enable asserted.
- `stb_ovfl_err` set (sticky until reset).

Issue:
- `stb_pcx_rq_vld` = (iptr != wptr) && commit[iptr idx].
- `stb_pcx_rq_ptr` = iptr idx.
- pcx_grant while rq_vld: iptr += 1 next cycle.
- pcx_grant while !rq_vld is ignored.

Ack:
- cpx_st_ack with dptr != iptr: valid[dptr idx] = 0, commit[dptr idx] = 0, dptr += 1.
- Otherwise ignored and `stb_unfl_err` set (sticky).

Same-cycle events:
- Write, grant and ack in one cycle are independent; all take effect together.
- count updates by (+write − flush − ack).
- An entry is never issued in the cycle it is written or in its W cycle.

Reset mid-operation:
- All state cleared next edge; in-flight grants and acks in that cycle are discarded.

Latency:
- Write to issuable: 2 cycles (M write, W commit, rq_vld in the following cycle).

Decomposition:
- Shared package (lsu_stb_pkg): STB_DEPTH, STB_PTRW, and a pointer typedef with wrap bit.
- One natural sub-module, `lsu_stb_ptr`: a wrap-bit pointer register with inc/dec enables.
  - Instantiated three times (write, issue, dealloc); dec is used only on the write pointer.
- Valid/commit arrays and the full/empty compare live in the top.

Test Plan:
- Reset, then 8 back-to-back st_wr_m with no flush → `stb_clk_en_l` = FE,FD,FB,…,7F; `stb_full` = 1 and `stb_cnt` = 8 after the 8th write; a 9th write gives all-ones enable and `stb_ovfl_err` = 1.
- Write entry 0, then st_flush_w next cycle → `stb_valid` = 00, wptr back to 0, `stb_pcx_rq_vld` never asserts; the next write again enables entry 0 (`stb_clk_en_l` = FE).
- Write entry 0, then in the next cycle assert st_wr_m with st_flush_w → second store writes index 0 (`stb_clk_en_l` = FE); `stb_cnt` = 1; rq_vld asserts 2 cycles later with `stb_pcx_rq_ptr` = 0.
- Fill 3 entries, grant 3 times, ack 3 times → rq_ptr sequence 0,1,2; `stb_empty` = 1 at end; a 4th ack sets `stb_unfl_err` = 1 and `stb_cnt` stays 0.
- Wrap: 8 writes, 8 grants/acks, then 4 writes → enables for indices 0..3; `stb_cnt` = 4; `stb_full` = 0 (wrap bit toggled).
- Full STB with same-cycle write-less ack and grant, then assert reset mid-stream → after the reset edge `stb_valid` = 00, `stb_clk_en_l` = FF, error flags = 0.
